clock_switch_sequencer: RTL and testbench
=========================================

CLOCK_SWITCH_SEQUENCER -- requirements
Module: clock_switch_sequencer

Interface
REQ-001 Parameter GATE_CYCLES, default 4: cycles the crypto-clock output is held off before and after a source change; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 64: consecutive pll_locked cycles required before the output is re-enabled; legal range 1..65535.
REQ-003 Parameter LOCK_TIMEOUT, default 1024: maximum cycles allowed in SETTLE; must exceed SETTLE_CYCLES; legal up to 65535.
REQ-004 Port usb_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port req_valid, input, 1 bit: a new clock-register value is offered.
REQ-007 Port req_clock_reg, input, 5 bits: the requested clock register value, in the same encoding as the clocks block I_clock_reg.
REQ-008 Port req_ready, output, 1 bit: the block can accept a request; high only in IDLE.
REQ-009 Port pll_locked, input, 1 bit: PLL1 lock indication, already synchronised to usb_clk.
REQ-010 Port err_clear, input, 1 bit: clears timeout_err.
REQ-011 Port O_clock_reg, output, 5 bits: drives the clocks block I_clock_reg.
REQ-012 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-013 Port done_pulse, output, 1 bit: one-cycle pulse when a request completes.
REQ-014 Port timeout_err, output, 1 bit: sticky flag set on a lock timeout.

Function
REQ-015 The FSM states shall be IDLE, GATE_OFF, SETTLE, GATE_ON and DONE.
REQ-016 A request shall be accepted when req_valid and req_ready are both high; on acceptance, req_clock_reg is latched as target and O_clock_reg is latched as prev.
REQ-017 An accepted request whose target equals the current O_clock_reg shall go directly to DONE, so that done_pulse occurs 1 cycle after acceptance.
REQ-018 Any other accepted request shall move to GATE_OFF.
REQ-019 GATE_OFF shall drive O_clock_reg = {2'b00, prev[2:1], 1'b1} (register mode, output off, old source) for exactly GATE_CYCLES cycles.
REQ-020 GATE_OFF shall then move to SETTLE.
REQ-021 SETTLE shall drive O_clock_reg = {2'b00, target[2:1], 1'b1} (register mode, output off, new source).
REQ-022 In SETTLE, a lock counter shall increment on each cycle pll_locked is high and clear to 0 on any cycle it is low.
REQ-023 In SETTLE, a timeout counter shall start at 0 on entry and increment every cycle.
REQ-024 SETTLE shall move to GATE_ON when the lock counter reaches SETTLE_CYCLES.
REQ-025 If the timeout counter reaches LOCK_TIMEOUT first, the block shall set timeout_err, restore O_clock_reg = prev, and move to DONE, skipping GATE_ON.
REQ-026 If the lock condition and the timeout condition occur in the same cycle, the lock condition shall win.
REQ-027 A target with target[2:0] == 3'b101 (external 20-pin source) shall satisfy the lock condition in SETTLE without checking pll_locked, completing after SETTLE_CYCLES cycles.
REQ-028 GATE_ON shall hold O_clock_reg = {2'b00, target[2:1], 1'b1} for GATE_CYCLES cycles.
REQ-029 On the last GATE_ON cycle, O_clock_reg shall become target and the FSM shall move to DONE.
REQ-030 DONE shall assert done_pulse for exactly 1 cycle and then return to IDLE.
REQ-031 req_ready shall rise in the cycle after DONE.
REQ-032 req_valid outside IDLE shall be ignored, with no queueing.
REQ-033 O_clock_reg shall change only on state-transition edges, never mid-state.
REQ-034 timeout_err shall clear on err_clear; if a set and a clear occur in the same cycle, the set shall win.
REQ-035 All counters shall saturate and never wrap.
REQ-036 Counter widths shall be sized for the parameter maxima.

Reset
REQ-037 While reset_n is low at a rising edge of usb_clk, the block shall force state = IDLE and O_clock_reg = 5'b00000 (DIP-switch mode).
REQ-038 The same reset shall force busy = 0, done_pulse = 0, timeout_err = 0, req_ready = 1 and all counters to 0.
REQ-039 A reset asserted mid-sequence shall abandon the request with no done_pulse, and O_clock_reg shall become 5'b00000 on the same edge.

Verification
REQ-040 Reset then req 5'b01001 with pll_locked = 1 -> O_clock_reg = 00001 for 4 cycles, 01001-masked 00001 for 64 cycles, 00001 for 4 cycles, then 01001; done_pulse at acceptance + 73.
REQ-041 Req equal to the current value -> done_pulse 1 cycle after acceptance; O_clock_reg unchanged throughout.
REQ-042 pll_locked dropped for 1 cycle at SETTLE cycle 30 -> SETTLE extends to 64 consecutive high cycles after the drop.
REQ-043 pll_locked = 0 throughout -> timeout_err = 1 at SETTLE cycle 1024, O_clock_reg = prev, done_pulse follows; err_clear asserted in the same cycle as the set leaves timeout_err = 1.
REQ-044 reset_n pulsed low during SETTLE -> O_clock_reg = 00000, busy = 0 and req_ready = 1 on the next edge, and no done_pulse.
REQ-045 req_valid held high during busy with a second value -> only the first request is executed; the second is accepted only once req_ready returns.

Source files
------------

// File: rtl/clock_switch_sequencer.sv
// Sequences a glitch-safe crypto-clock source change: gate off, retarget and wait for lock, gate on.
// Request handshake is valid/ready; ready only in IDLE, offers outside IDLE are dropped.
module clock_switch_sequencer #(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic       usb_clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [4:0] req_clock_reg,
    output logic       req_ready,
    input  logic       pll_locked,
    input  logic       err_clear,
    output logic [4:0] O_clock_reg,
    output logic       busy,
    output logic       done_pulse,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GATE_OFF = 3'd1,
        SETTLE   = 3'd2,
        GATE_ON  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0]  GATE_LAST = 8'(GATE_CYCLES - 1);
    localparam logic [15:0] SETTLE_N  = 16'(SETTLE_CYCLES);
    localparam logic [15:0] TMO_N     = 16'(LOCK_TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  target;
    logic [4:0]  prev;
    logic [7:0]  gate_cnt;
    logic [15:0] lock_cnt;
    logic [15:0] tmo_cnt;

    logic        accept;
    logic        gate_done;
    logic        src_ok;
    logic [15:0] lock_nxt;
    logic [15:0] tmo_nxt;
    logic        lock_hit;
    logic        tmo_hit;
    logic        set_err;

    assign accept    = req_valid && (state == IDLE);
    assign gate_done = (gate_cnt == GATE_LAST);
    // The external 20-pin source has no PLL in its path, so treat it as always locked.
    assign src_ok    = pll_locked || (target[2:0] == 3'b101);
    assign lock_nxt  = !src_ok ? 16'd0 : ((lock_cnt == 16'hFFFF) ? lock_cnt : lock_cnt + 16'd1);
    assign tmo_nxt   = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
    assign lock_hit  = (lock_nxt >= SETTLE_N);
    assign tmo_hit   = (tmo_nxt >= TMO_N);
    assign set_err   = (state == SETTLE) && !lock_hit && tmo_hit;

    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (req_clock_reg == O_clock_reg) ? DONE : GATE_OFF;
                end
            end
            GATE_OFF: begin
                if (gate_done) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (lock_hit) begin
                    state_nxt = GATE_ON;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            GATE_ON: begin
                if (gate_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        done_pulse = (state == DONE);
    end

    // O_clock_reg only moves on the edge that leaves a state, so the clocks block never sees a mid-state change.
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            O_clock_reg <= 5'b00000;
            target      <= 5'b00000;
            prev        <= 5'b00000;
            gate_cnt    <= 8'd0;
            lock_cnt    <= 16'd0;
            tmo_cnt     <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= set_err || (timeout_err && !err_clear);
            case (state)
                IDLE: begin
                    gate_cnt <= 8'd0;
                    lock_cnt <= 16'd0;
                    tmo_cnt  <= 16'd0;
                    if (accept) begin
                        target <= req_clock_reg;
                        prev   <= O_clock_reg;
                        if (req_clock_reg != O_clock_reg) begin
                            O_clock_reg <= {2'b00, O_clock_reg[2:1], 1'b1};
                        end
                    end
                end
                GATE_OFF: begin
                    if (gate_done) begin
                        gate_cnt    <= 8'd0;
                        lock_cnt    <= 16'd0;
                        tmo_cnt     <= 16'd0;
                        O_clock_reg <= {2'b00, target[2:1], 1'b1};
                    end else begin
                        gate_cnt <= gate_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    lock_cnt <= lock_nxt;
                    tmo_cnt  <= tmo_nxt;
                    if (lock_hit) begin
                        gate_cnt <= 8'd0;
                    end else if (tmo_hit) begin
                        O_clock_reg <= prev;
                    end
                end
                GATE_ON: begin
                    if (gate_done) begin
                        O_clock_reg <= target;
                    end else begin
                        gate_cnt <= gate_cnt + 8'd1;
                    end
                end
                default: begin
                    gate_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Scenario bench for clock_switch_sequencer: per-cycle phase checks plus a done-time scoreboard.
module tb_clock_switch_sequencer;

    logic       usb_clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [4:0] req_clock_reg;
    logic       req_ready;
    logic       pll_locked;
    logic       err_clear;
    logic [4:0] O_clock_reg;
    logic       busy;
    logic       done_pulse;
    logic       timeout_err;

    clock_switch_sequencer dut (
        .usb_clk       (usb_clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_clock_reg (req_clock_reg),
        .req_ready     (req_ready),
        .pll_locked    (pll_locked),
        .err_clear     (err_clear),
        .O_clock_reg   (O_clock_reg),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .timeout_err   (timeout_err)
    );

    always #5 usb_clk = ~usb_clk;

    int cyc = 0;
    always @(posedge usb_clk) cyc <= cyc + 1;

    typedef struct {
        int         done_rel;
        logic [4:0] o;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         acc      = 0;
    logic [4:0] cur_o    = 5'b00000;

    // Called at a negedge; offers v in the current cycle once req_ready is seen.
    task automatic issue(input logic [4:0] v);
        int n;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge usb_clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        req_valid     = 1'b1;
        req_clock_reg = v;
        acc           = cyc;
    endtask

    task automatic track(input logic [4:0] req, input int settle_len, input bit tmo,
                         input int drop_rel, input bit pll_low, input bit clr,
                         input bit hold, input logic [4:0] nxt);
        logic [4:0] prev;
        logic [4:0] off_o;
        logic [4:0] on_o;
        logic [4:0] exp_o;
        bit         same;
        exp_t       e;
        exp_t       got;
        prev  = cur_o;
        same  = (req == prev);
        off_o = {2'b00, prev[2:1], 1'b1};
        on_o  = {2'b00, req[2:1], 1'b1};
        if (same) begin
            e.done_rel = 1; e.o = prev; e.err = 1'b0;
        end else if (tmo) begin
            e.done_rel = 5 + settle_len; e.o = prev; e.err = 1'b1;
        end else begin
            e.done_rel = 9 + settle_len; e.o = req; e.err = 1'b0;
        end
        sb.push_back(e);
        pll_locked = !pll_low;
        issue(req);
        for (int r = 1; r <= e.done_rel; r++) begin
            @(negedge usb_clk);
            if (r == 1) begin
                req_valid     = hold;
                req_clock_reg = nxt;
            end
            pll_locked = pll_low ? 1'b0 : (r != drop_rel);
            err_clear  = clr && (r == e.done_rel - 1);
            exp_o = same ? prev : ((r <= 4) ? off_o : on_o);
            if (r == e.done_rel) begin
                got = sb.pop_front();
                checks++;
                if (O_clock_reg !== got.o) begin
                    failures++;
                    $display("FAIL done_o req=%b: O_clock_reg=%b required %b", req, O_clock_reg, got.o);
                end
                checks++;
                if (timeout_err !== got.err) begin
                    failures++;
                    $display("FAIL done_err req=%b: timeout_err=%b required %b", req, timeout_err, got.err);
                end
            end else begin
                checks++;
                if (O_clock_reg !== exp_o) begin
                    failures++;
                    $display("FAIL phase_o req=%b rel=%0d: O_clock_reg=%b required %b", req, r, O_clock_reg, exp_o);
                end
            end
            checks++;
            if (done_pulse !== (r == e.done_rel)) begin
                failures++;
                $display("FAIL done_pulse req=%b rel=%0d: done_pulse=%b required %b", req, r, done_pulse, (r == e.done_rel));
            end
            checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy req=%b rel=%0d: busy=%b req_ready=%b required 1 0", req, r, busy, req_ready);
            end
        end
        err_clear  = 1'b0;
        pll_locked = 1'b1;
        cur_o      = e.o;
        @(negedge usb_clk);
        checks++;
        if (req_ready !== 1'b1 || done_pulse !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done req=%b: req_ready=%b done_pulse=%b busy=%b required 1 0 0", req, req_ready, done_pulse, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_clock_reg = 5'b00000;
        pll_locked = 1'b1; err_clear = 1'b0;
        repeat (3) @(negedge usb_clk);
        checks++;
        if (O_clock_reg !== 5'b00000 || busy !== 1'b0 || done_pulse !== 1'b0 ||
            timeout_err !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: O=%b busy=%b done=%b err=%b ready=%b required 00000 0 0 0 1",
                     O_clock_reg, busy, done_pulse, timeout_err, req_ready);
        end
        reset_n = 1'b1;
        @(negedge usb_clk);
        cur_o = 5'b00000;
    endtask

    task automatic test_basic();
        track(5'b01001, 64, 1'b0, -1, 1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic test_same();
        track(5'b01001, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic test_switch();
        track(5'b10011, 64, 1'b0, -1, 1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic test_lock_drop();
        // SETTLE cycle 30 is rel 34; 29 + 1 dropped + 64 consecutive = 94 SETTLE cycles.
        track(5'b01001, 94, 1'b0, 34, 1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic test_ext_source();
        track(5'b01101, 64, 1'b0, -1, 1'b1, 1'b0, 1'b0, 5'b00000);
    endtask

    task automatic test_timeout();
        track(5'b10011, 1024, 1'b1, -1, 1'b1, 1'b1, 1'b0, 5'b00000);
        repeat (3) @(negedge usb_clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: timeout_err=%b required 1", timeout_err);
        end
        err_clear = 1'b1;
        @(negedge usb_clk);
        err_clear = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: timeout_err=%b required 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        pll_locked = 1'b1;
        issue(5'b10110);
        @(negedge usb_clk);
        req_valid = 1'b0;
        repeat (19) @(negedge usb_clk);
        reset_n = 1'b0;
        @(negedge usb_clk);
        reset_n = 1'b1;
        checks++;
        if (O_clock_reg !== 5'b00000 || busy !== 1'b0 || req_ready !== 1'b1 || done_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: O=%b busy=%b ready=%b done=%b required 00000 0 1 0",
                     O_clock_reg, busy, req_ready, done_pulse);
        end
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge usb_clk);
            if (done_pulse === 1'b1 || O_clock_reg !== 5'b00000) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid_quiet: activity after reset seen=%b required 0", saw_done);
        end
        cur_o = 5'b00000;
    endtask

    task automatic test_back_to_back();
        track(5'b00011, 64, 1'b0, -1, 1'b0, 1'b0, 1'b1, 5'b01010);
        track(5'b01010, 64, 1'b0, -1, 1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same();
        test_switch();
        test_lock_drop();
        test_ext_source();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
